// File: rtl/fir_pkg.sv
// Shared definitions for the FIR host sequencer and the FIR controller.
// Holds the default filter geometry, the sequencer state encoding and
// helpers that turn a depth or limit into a bit width.
package fir_pkg;

    localparam int N_WSP_DEF    = 16;
    localparam int N_PROBEK_DEF = 64;
    localparam int DATA_W_DEF   = 16;
    localparam int WYN_W_DEF    = 40;
    localparam int TIMEOUT_DEF  = 4096;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_WSP,
        LOAD_PRB,
        START_P,
        CZEKAJ,
        ODCZ_ADR,
        ODCZ_DANE,
        GOTOWE,
        BLAD
    } stan_t;

    // Address width for a memory of n words (at least one bit).
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold values up to n without wrapping.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/fir_host_seq_if.sv
// Bus bundle between the host sequencer and its surroundings:
//   coefficient / sample input streams (valid/ready/data),
//   coefficient / sample RAM write ports, result RAM read port,
//   FIR controller handshake (START, pracuje, DONE),
//   result output stream (valid/ready/data).
// master: the sequencer; slave: the system / FIR core side.
interface fir_host_seq_if #(
    parameter int N_WSP    = fir_pkg::N_WSP_DEF,
    parameter int N_PROBEK = fir_pkg::N_PROBEK_DEF,
    parameter int DATA_W   = fir_pkg::DATA_W_DEF,
    parameter int WYN_W    = fir_pkg::WYN_W_DEF
) ();
    import fir_pkg::*;

    localparam int WAW = addr_w(N_WSP);
    localparam int PAW = addr_w(N_PROBEK);

    logic              wsp_valid;
    logic              wsp_ready;
    logic [DATA_W-1:0] wsp_data;
    logic              prb_valid;
    logic              prb_ready;
    logic [DATA_W-1:0] prb_data;

    logic              wsp_we;
    logic [WAW-1:0]    wsp_addr;
    logic [DATA_W-1:0] wsp_wdata;
    logic              prb_we;
    logic [PAW-1:0]    prb_addr;
    logic [DATA_W-1:0] prb_wdata;
    logic              wyn_re;
    logic [PAW-1:0]    wyn_addr;
    logic [WYN_W-1:0]  wyn_rdata;

    logic              START;
    logic              pracuje;
    logic              DONE;

    logic              out_valid;
    logic              out_ready;
    logic [WYN_W-1:0]  out_data;

    modport master (
        input  wsp_valid, wsp_data, prb_valid, prb_data, wyn_rdata,
               pracuje, DONE, out_ready,
        output wsp_ready, prb_ready, wsp_we, wsp_addr, wsp_wdata,
               prb_we, prb_addr, prb_wdata, wyn_re, wyn_addr,
               START, out_valid, out_data
    );

    modport slave (
        output wsp_valid, wsp_data, prb_valid, prb_data, wyn_rdata,
               pracuje, DONE, out_ready,
        input  wsp_ready, prb_ready, wsp_we, wsp_addr, wsp_wdata,
               prb_we, prb_addr, prb_wdata, wyn_re, wyn_addr,
               START, out_valid, out_data
    );

endinterface

// File: rtl/fir_host_licznik.sv
// Saturating up-counter with synchronous clear.
//   en    : count one step (ignored once cnt == limit)
//   clr   : return to zero, wins over en
//   limit : terminal value
//   cnt   : current value
//   last  : cnt == limit
module fir_host_licznik #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fir_host_seq.sv
// Host-side sequencer for the FIR datapath.
// Loads N_WSP coefficients and N_PROBEK samples from two input streams into
// the filter RAMs, pulses START, waits for DONE (bounded by TIMEOUT), then
// reads the result RAM and streams the results out.
//   clk, rst_n : clock, asynchronous active-low reset
//   run_req    : request a run (accepted in IDLE or BLAD)
//   busy       : run in progress
//   err        : DONE did not arrive in time; held until the next run
//   bus        : streams, RAM ports and FIR controller handshake
module fir_host_seq
    import fir_pkg::*;
#(
    parameter int N_WSP    = N_WSP_DEF,
    parameter int N_PROBEK = N_PROBEK_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WYN_W    = WYN_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_req,
    output logic busy,
    output logic err,
    fir_host_seq_if.master bus
);

    localparam int WAW  = addr_w(N_WSP);
    localparam int PAW  = addr_w(N_PROBEK);
    localparam int NMAX = (N_WSP > N_PROBEK) ? N_WSP : N_PROBEK;
    localparam int CW   = cnt_w(NMAX);
    localparam int TW   = cnt_w(TIMEOUT);

    stan_t            state;
    logic             first_reg;
    logic [WYN_W-1:0] hold_reg;

    logic          idx_en, idx_clr, idx_last;
    logic [CW-1:0] idx_limit, idx_cnt, idx_nxt;
    logic          tmo_en, tmo_clr, tmo_last;
    logic [TW-1:0] tmo_cnt;
    logic          wsp_fire, prb_fire, out_fire, accept;
    logic          unused_sig;

    assign wsp_fire = bus.wsp_ready & bus.wsp_valid;
    assign prb_fire = bus.prb_ready & bus.prb_valid;
    assign out_fire = bus.out_valid & bus.out_ready;
    assign accept   = run_req && (state == IDLE || state == BLAD);
    assign idx_nxt  = idx_cnt + 1'b1;

    // RAM writes follow the accepted beat in the same cycle; address and
    // data are forced to zero when nothing is written.
    assign bus.wsp_we    = wsp_fire;
    assign bus.wsp_addr  = wsp_fire ? idx_cnt[WAW-1:0] : '0;
    assign bus.wsp_wdata = wsp_fire ? bus.wsp_data : '0;
    assign bus.prb_we    = prb_fire;
    assign bus.prb_addr  = prb_fire ? idx_cnt[PAW-1:0] : '0;
    assign bus.prb_wdata = prb_fire ? bus.prb_data : '0;

    // Result RAM data arrives in the first ODCZ_DANE cycle; it is passed
    // straight through then and held from the register afterwards, so a
    // result is presented every second cycle and stays stable under stall.
    assign bus.out_data = first_reg ? bus.wyn_rdata : hold_reg;

    // The FIR core's busy flag carries no information for this sequencer.
    assign unused_sig = ^{idx_cnt, idx_nxt, tmo_cnt, bus.pracuje};

    always_comb begin
        idx_en    = 1'b0;
        idx_clr   = 1'b0;
        idx_limit = CW'(N_PROBEK - 1);
        case (state)
            IDLE, BLAD: idx_clr = run_req;
            LOAD_WSP: begin
                idx_limit = CW'(N_WSP - 1);
                if (wsp_fire) begin
                    idx_clr = idx_last;
                    idx_en  = !idx_last;
                end
            end
            LOAD_PRB: begin
                if (prb_fire) begin
                    idx_clr = idx_last;
                    idx_en  = !idx_last;
                end
            end
            CZEKAJ:    idx_clr = bus.DONE;
            ODCZ_DANE: idx_en  = out_fire && !idx_last;
            default: ;
        endcase
    end

    assign tmo_en  = (state == CZEKAJ);
    assign tmo_clr = (state == START_P) || accept;

    fir_host_licznik #(.W(CW)) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (idx_en),
        .clr   (idx_clr),
        .limit (idx_limit),
        .cnt   (idx_cnt),
        .last  (idx_last)
    );

    fir_host_licznik #(.W(TW)) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tmo_en),
        .clr   (tmo_clr),
        .limit (TW'(TIMEOUT - 1)),
        .cnt   (tmo_cnt),
        .last  (tmo_last)
    );

    // Outputs are registered: each one is set on the transition into the
    // state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            err           <= 1'b0;
            bus.wsp_ready <= 1'b0;
            bus.prb_ready <= 1'b0;
            bus.START     <= 1'b0;
            bus.wyn_re    <= 1'b0;
            bus.wyn_addr  <= '0;
            bus.out_valid <= 1'b0;
            first_reg     <= 1'b0;
            hold_reg      <= '0;
        end else begin
            bus.START  <= 1'b0;
            bus.wyn_re <= 1'b0;
            first_reg  <= 1'b0;
            case (state)
                IDLE, BLAD: begin
                    if (run_req) begin
                        state         <= LOAD_WSP;
                        busy          <= 1'b1;
                        err           <= 1'b0;
                        bus.wsp_ready <= 1'b1;
                    end
                end
                LOAD_WSP: begin
                    if (wsp_fire && idx_last) begin
                        state         <= LOAD_PRB;
                        bus.wsp_ready <= 1'b0;
                        bus.prb_ready <= 1'b1;
                    end
                end
                LOAD_PRB: begin
                    if (prb_fire && idx_last) begin
                        state         <= START_P;
                        bus.prb_ready <= 1'b0;
                        bus.START     <= 1'b1;
                    end
                end
                START_P: state <= CZEKAJ;
                CZEKAJ: begin
                    // DONE on the limit cycle still counts as success.
                    if (bus.DONE) begin
                        state        <= ODCZ_ADR;
                        bus.wyn_re   <= 1'b1;
                        bus.wyn_addr <= '0;
                    end else if (tmo_last) begin
                        state <= BLAD;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end
                end
                ODCZ_ADR: begin
                    state         <= ODCZ_DANE;
                    bus.out_valid <= 1'b1;
                    first_reg     <= 1'b1;
                end
                ODCZ_DANE: begin
                    if (first_reg) begin
                        hold_reg <= bus.wyn_rdata;
                    end
                    if (out_fire) begin
                        bus.out_valid <= 1'b0;
                        if (idx_last) begin
                            state <= GOTOWE;
                        end else begin
                            state        <= ODCZ_ADR;
                            bus.wyn_re   <= 1'b1;
                            bus.wyn_addr <= idx_nxt[PAW-1:0];
                        end
                    end
                end
                GOTOWE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_host_seq.sv
// Directed bench for fir_host_seq with N_WSP=4, N_PROBEK=4, TIMEOUT=16.
// Simple RAM models sit on the write and result-read ports; a monitor
// records START pulses and every accepted output beat.
module tb_fir_host_seq;
    import fir_pkg::*;

    localparam int NW = 4;
    localparam int NP = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic run_req;
    logic busy;
    logic err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cnt = 0;
    logic [39:0] got[$];
    int          got_cyc[$];

    logic [15:0] wsp_mem [NW];
    logic [15:0] prb_mem [NP];
    logic [39:0] res_mem [NP];

    fir_host_seq_if #(.N_WSP(NW), .N_PROBEK(NP), .DATA_W(16), .WYN_W(40)) bus ();

    fir_host_seq #(
        .N_WSP(NW), .N_PROBEK(NP), .DATA_W(16), .WYN_W(40), .TIMEOUT(TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run_req (run_req),
        .busy    (busy),
        .err     (err),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.wsp_we === 1'b1) wsp_mem[bus.wsp_addr] <= bus.wsp_wdata;
        if (bus.prb_we === 1'b1) prb_mem[bus.prb_addr] <= bus.prb_wdata;
        if (bus.wyn_re === 1'b1) bus.wyn_rdata <= res_mem[bus.wyn_addr];
        if (bus.START === 1'b1) start_cnt <= start_cnt + 1;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got.push_back(bus.out_data);
            got_cyc.push_back(cyc);
            $display("out beat data=%0d cycle=%0d", bus.out_data, cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one beat after `gap` idle cycles and hold it until accepted.
    task automatic send(input bit prb, input logic [15:0] d, input int gap, input int exp_addr);
        int n = 0;
        repeat (gap) @(negedge clk);
        if (prb) begin
            bus.prb_valid = 1'b1;
            bus.prb_data  = d;
        end else begin
            bus.wsp_valid = 1'b1;
            bus.wsp_data  = d;
        end
        while (((prb ? bus.prb_ready : bus.wsp_ready) !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (prb) begin
            check("prb_we", bus.prb_we, 1);
            check("prb_addr", bus.prb_addr, exp_addr);
            check("prb_wdata", bus.prb_wdata, d);
        end else begin
            check("wsp_we", bus.wsp_we, 1);
            check("wsp_addr", bus.wsp_addr, exp_addr);
            check("wsp_wdata", bus.wsp_wdata, d);
        end
        $display("%s beat addr=%0d data=%0d", prb ? "prb" : "wsp", exp_addr, d);
        @(negedge clk);
        bus.prb_valid = 1'b0;
        bus.wsp_valid = 1'b0;
    endtask

    // Wait for a result, stall it `stall` cycles, then accept it.
    task automatic recv(input logic [39:0] exp, input int stall);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("out_valid", bus.out_valid, 1);
        repeat (stall) begin
            @(negedge clk);
            check("out_hold", {bus.out_valid, bus.out_data}, {1'b1, exp});
        end
        check("out_data", bus.out_data, exp);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic start_run();
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
        check("run_busy", busy, 1);
        check("run_err", err, 0);
        check("run_wsp_ready", bus.wsp_ready, 1);
    endtask

    task automatic load_fast(input logic [15:0] base);
        for (int i = 0; i < NW; i++) send(1'b0, base + 16'(i), 0, i);
        for (int i = 0; i < NP; i++) send(1'b1, base + 16'h10 + 16'(i), 0, i);
        check("start_pulse", bus.START, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        run_req = 1'b0;
        bus.wsp_valid = 1'b0; bus.wsp_data = '0;
        bus.prb_valid = 1'b0; bus.prb_data = '0;
        bus.pracuje = 1'b0; bus.DONE = 1'b0; bus.out_ready = 1'b0;

        // reset state
        #1;
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_wsp_ready", bus.wsp_ready, 0);
        check("rst_START", bus.START, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_wyn_re", bus.wyn_re, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // nominal run, continuous streams, out_ready held high
        for (int i = 0; i < NP; i++) res_mem[i] = 40'd100 + 40'(i);
        start_run();
        for (int i = 0; i < NW; i++) send(1'b0, 16'(i + 1), 0, i);
        for (int i = 0; i < NP; i++) send(1'b1, 16'((i + 1) * 10), 0, i);
        check("nom_start", bus.START, 1);
        @(negedge clk);
        check("nom_start_single", bus.START, 0);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.DONE = 1'b1;
        @(negedge clk);
        bus.DONE = 1'b0;
        n = 0;
        while (got.size() < 4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("nom_count", got.size(), 4);
        check("nom_busy_gotowe", busy, 1);
        @(negedge clk);
        check("nom_busy_drop", busy, 0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < NP; i++) check("nom_data", got[i], 100 + i);
        check("nom_rate", got_cyc[3] - got_cyc[0], 6);
        check("nom_starts", start_cnt, 1);
        for (int i = 0; i < NW; i++) check("nom_wsp_mem", wsp_mem[i], i + 1);
        for (int i = 0; i < NP; i++) check("nom_prb_mem", prb_mem[i], (i + 1) * 10);
        got.delete();
        got_cyc.delete();

        // gaps, spurious DONE/pracuje/run_req, output backpressure
        for (int i = 0; i < NP; i++) res_mem[i] = 40'd200 + 40'(i);
        start_run();
        send(1'b0, 16'h0011, 1, 0);
        bus.DONE = 1'b1;
        bus.pracuje = 1'b1;
        @(negedge clk);
        bus.DONE = 1'b0;
        bus.pracuje = 1'b0;
        check("spur_wsp_ready", bus.wsp_ready, 1);
        check("spur_no_start", bus.START, 0);
        for (int i = 1; i < NW; i++) send(1'b0, 16'h0011 + 16'(i), $urandom_range(0, 2), i);
        for (int i = 0; i < NP; i++) send(1'b1, 16'h0100 + 16'(i), $urandom_range(0, 3), i);
        check("bp_start", bus.START, 1);
        @(negedge clk);
        run_req = 1'b1;
        bus.pracuje = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
        bus.pracuje = 1'b0;
        check("spur_run_busy", busy, 1);
        check("spur_run_wsp_ready", bus.wsp_ready, 0);
        check("spur_run_starts", start_cnt, 2);
        bus.DONE = 1'b1;
        @(negedge clk);
        bus.DONE = 1'b0;
        recv(40'd200, 0);
        recv(40'd201, 3);
        recv(40'd202, 0);
        recv(40'd203, 1);
        @(negedge clk);
        check("bp_busy_drop", busy, 0);
        check("bp_count", got.size(), 4);
        check("bp_starts", start_cnt, 2);
        check("bp_wsp_mem0", wsp_mem[0], 16'h0011);
        check("bp_wsp_mem3", wsp_mem[3], 16'h0014);
        check("bp_prb_mem2", prb_mem[2], 16'h0102);

        // timeout: no DONE; BLAD comes TIMEOUT cycles after START falls
        start_run();
        load_fast(16'h0200);
        n = 0;
        while (err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", n, TO + 1);
        check("tmo_err", err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_wsp_ready", bus.wsp_ready, 0);
        check("tmo_out_valid", bus.out_valid, 0);
        repeat (3) @(negedge clk);
        check("blad_err_held", err, 1);

        // new run from BLAD clears err; DONE exactly on the limit cycle
        for (int i = 0; i < NP; i++) res_mem[i] = 40'd300 + 40'(i);
        start_run();
        load_fast(16'h0300);
        repeat (TO) @(negedge clk);
        check("race_pre_err", err, 0);
        check("race_pre_busy", busy, 1);
        bus.DONE = 1'b1;
        @(negedge clk);
        bus.DONE = 1'b0;
        check("race_err", err, 0);
        for (int i = 0; i < NP; i++) recv(40'd300 + 40'(i), 0);
        check("race_starts", start_cnt, 4);

        // asynchronous reset in the middle of LOAD_PRB
        repeat (2) @(negedge clk);
        start_run();
        for (int i = 0; i < NW; i++) send(1'b0, 16'h0400 + 16'(i), 0, i);
        for (int i = 0; i < 2; i++) send(1'b1, 16'h0410 + 16'(i), 0, i);
        bus.prb_valid = 1'b1;
        bus.prb_data = 16'h0412;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_prb_ready", bus.prb_ready, 0);
        check("arst_prb_we", bus.prb_we, 0);
        check("arst_prb_addr", bus.prb_addr, 0);
        check("arst_START", bus.START, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.prb_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("arst_no_start", start_cnt, 4);
        check("arst_idle_busy", busy, 0);
        check("arst_idle_wsp_ready", bus.wsp_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_host_seq.md
Name: fir_host_seq

Overview:
Host-side initiator for the FIR datapath controller. It streams coefficients and input samples into the filter memories, pulses START, and waits for DONE with a timeout. It then reads the result memory and streams results out on a valid/ready port. It sits between the system bus/stream logic and the FIR core, driving the core's START and consuming its pracuje/DONE.

Parameters:
N_WSP, 16, number of filter coefficients (taps), >=2
N_PROBEK, 64, number of input samples per run, >=2
DATA_W, 16, coefficient/sample width
WYN_W, 40, result (accumulator) width
TIMEOUT, 4096, max cycles from START to DONE before error

Ports:
clk  in  1  single clock
rst_n  in  1  reset, asynchronous, active-low
run_req  in  1  one-cycle request to begin a run
busy  out  1  high from accepted run_req until GOTOWE/BLAD exit
err  out  1  timeout flag; sticky until next accepted run_req
wsp_valid / wsp_ready / wsp_data  in/out/in  1/1/DATA_W  coefficient stream
prb_valid / prb_ready / prb_data  in/out/in  1/1/DATA_W  sample stream
wsp_we / wsp_addr / wsp_wdata  out  1/$clog2(N_WSP)/DATA_W  coefficient RAM write
prb_we / prb_addr / prb_wdata  out  1/$clog2(N_PROBEK)/DATA_W  sample RAM write
wyn_re / wyn_addr  out  1/$clog2(N_PROBEK)  result RAM read, rdata valid 1 cycle after wyn_re
wyn_rdata  in  WYN_W  result RAM data
START  out  1  one-cycle start pulse to FIR controller
pracuje  in  1  FIR core busy
DONE  in  1  FIR core completion pulse
out_valid / out_ready / out_data  out/in/out  1/1/WYN_W  result stream

Behaviour:
- Reset (async, rst_n low): state IDLE, all counters 0. Every output 0: busy, err, all readies/valids/we/re, START, addresses and data.
- States: IDLE, LOAD_WSP, LOAD_PRB, START_P, CZEKAJ, ODCZ_ADR, ODCZ_DANE, GOTOWE, BLAD.
- IDLE: on run_req, go to LOAD_WSP. Clear err, clear counters, assert busy. run_req outside IDLE is ignored.
- LOAD_WSP: wsp_ready=1. On wsp_valid&&wsp_ready: wsp_we=1, wsp_addr=cnt, wsp_wdata=wsp_data (combinational, same cycle), cnt++. On transfer with cnt==N_WSP-1: cnt cleared, go to LOAD_PRB.
- LOAD_PRB: same scheme on prb_* with N_PROBEK. Last beat goes to START_P.
- START_P: START=1 for exactly one cycle. Clear the timeout counter, go to CZEKAJ.
- CZEKAJ: timeout counter increments each cycle.
  - DONE=1: go to ODCZ_ADR with cnt=0.
  - Counter reaches TIMEOUT-1 without DONE: go to BLAD.
  - DONE on the same cycle as the timeout limit: DONE wins.
- DONE or pracuje in any state other than CZEKAJ is ignored.
- ODCZ_ADR: wyn_re=1, wyn_addr=cnt, go to ODCZ_DANE.
- ODCZ_DANE: out_valid=1, out_data=wyn_rdata captured into a register on entry.
  - out_data must be stable while out_valid && !out_ready.
  - On handshake with cnt==N_PROBEK-1: go to GOTOWE. Otherwise cnt++ and go to ODCZ_ADR.
  - Throughput is one result per 2 cycles minimum.
- GOTOWE: one cycle, busy=1, then IDLE; busy drops the cycle after.
- BLAD: err=1, busy=0, no stream activity. Next run_req behaves as from IDLE and clears err.
- Counters are unsigned, sized $clog2(max)+1 internally, and never wrap beyond their limit.
- Stream inputs outside their load state are not accepted (ready=0). Data on them is ignored.
- rst_n asserted mid-run aborts immediately. No START is issued afterwards unless a new run_req arrives.

Decomposition:
- Package fir_pkg: state enum (3 or 4 bits) and a localparam function for address widths, shared with the FIR controller's parameters (N_WSP, N_PROBEK).
- One natural sub-module: fir_host_licznik, a generic load/limit counter (en, clr, limit → cnt, last). Instanced for the load/read index and for the timeout.

Test Plan:
- Nominal run, N_WSP=4, N_PROBEK=4: coefficients 1,2,3,4 and samples 10,20,30,40 fed continuously → wsp_we at addr 0..3, prb_we at addr 0..3. Exactly one START pulse. After DONE, a model RAM holding 100..103 produces out_data 100,101,102,103 in order. busy falls after GOTOWE.
- Backpressure and gaps: random wsp_valid/prb_valid gaps and out_ready low for 3 cycles mid-read → no lost or duplicated beats, out_data stable while stalled.
- Timeout, TIMEOUT=16: DONE never asserted → BLAD entered 16 cycles after START, err=1, busy=0. A following run_req clears err and runs normally.
- Race: DONE asserted exactly on the timeout-limit cycle → readout proceeds, err stays 0.
- Spurious signals: DONE and pracuje pulsed during LOAD_WSP, and run_req pulsed during CZEKAJ → no state change, no extra START.
- Reset mid-LOAD_PRB, rst_n low 2 cycles → all outputs 0 immediately (async). After release, idle with no START until a new run_req.
